// File: rtl/sq_carry_resolve.sv
// Carry resolver for the squarer's redundant product: ripples pending carries one
// full-width pass per cycle, then offers the clean product on a valid/ready port.
// Optional pass counter port guarded by SQ_RESOLVE_PASSCNT_EN.
module sq_carry_resolve #(
    parameter int NUM_DIGITS = 130,
    parameter int DIGIT_W    = 16,
    parameter int CNT_W      = 8
) (
    input  logic                                   clk_sq,
    input  logic                                   reset_sq,
    input  logic                                   start,
    input  logic [NUM_DIGITS-1:0][DIGIT_W:0]       in_digits,
    output logic                                   busy,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [NUM_DIGITS-1:0][DIGIT_W-1:0]     out_digits,
    output logic                                   carry_out
`ifdef SQ_RESOLVE_PASSCNT_EN
    ,
    output logic [CNT_W-1:0]                       pass_cnt
`endif
);

    // Handshake: out_valid rises once the product is clean and holds, with
    // out_digits/carry_out frozen, until the edge where out_ready=1 is seen;
    // out_ready is a don't-care while out_valid=0.

    if ((2 ** CNT_W) <= NUM_DIGITS) begin : g_cnt_w_check
        $error("CNT_W too small for NUM_DIGITS passes");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [NUM_DIGITS-1:0][DIGIT_W:0]   work_q, work_d;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] out_digits_q, out_digits_d;
    logic                               out_valid_q, out_valid_d;
    logic                               carry_out_q, carry_out_d;
    logic                               any_carry;
`ifdef SQ_RESOLVE_PASSCNT_EN
    logic [CNT_W-1:0]                   pass_cnt_q, pass_cnt_d;
`endif

    always_comb begin
        any_carry = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            any_carry = any_carry | work_q[i][DIGIT_W];
        end
    end

    // State register
    always_ff @(posedge clk_sq or negedge reset_sq) begin
        if (!reset_sq) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = PROP;
            PROP:    if (!any_carry) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q != IDLE);
    end

    // Datapath next values
    always_comb begin
        work_d       = work_q;
        out_digits_d = out_digits_q;
        out_valid_d  = out_valid_q;
        carry_out_d  = carry_out_q;
`ifdef SQ_RESOLVE_PASSCNT_EN
        pass_cnt_d   = pass_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d      = in_digits;
                    carry_out_d = 1'b0;
`ifdef SQ_RESOLVE_PASSCNT_EN
                    pass_cnt_d  = '0;
`endif
                end
            end
            PROP: begin
                if (!any_carry) begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        out_digits_d[i] = work_q[i][DIGIT_W-1:0];
                    end
                    out_valid_d = 1'b1;
                end else begin
                    // Each digit absorbs its lower neighbour's carry; a carry only
                    // survives where the digit was all ones.
                    work_d[0] = {1'b0, work_q[0][DIGIT_W-1:0]};
                    for (int i = 1; i < NUM_DIGITS; i++) begin
                        work_d[i] = {1'b0, work_q[i][DIGIT_W-1:0]}
                                  + {{DIGIT_W{1'b0}}, work_q[i-1][DIGIT_W]};
                    end
                    carry_out_d = carry_out_q | work_q[NUM_DIGITS-1][DIGIT_W];
`ifdef SQ_RESOLVE_PASSCNT_EN
                    if (pass_cnt_q != {CNT_W{1'b1}}) begin
                        pass_cnt_d = pass_cnt_q + CNT_W'(1);
                    end
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_sq or negedge reset_sq) begin
        if (!reset_sq) begin
            work_q       <= '0;
            out_digits_q <= '0;
            out_valid_q  <= 1'b0;
            carry_out_q  <= 1'b0;
`ifdef SQ_RESOLVE_PASSCNT_EN
            pass_cnt_q   <= '0;
`endif
        end else begin
            work_q       <= work_d;
            out_digits_q <= out_digits_d;
            out_valid_q  <= out_valid_d;
            carry_out_q  <= carry_out_d;
`ifdef SQ_RESOLVE_PASSCNT_EN
            pass_cnt_q   <= pass_cnt_d;
`endif
        end
    end

    assign out_digits = out_digits_q;
    assign out_valid  = out_valid_q;
    assign carry_out  = carry_out_q;
`ifdef SQ_RESOLVE_PASSCNT_EN
    assign pass_cnt   = pass_cnt_q;
`endif

endmodule

// File: tb/tb_sq_carry_resolve.sv
// Self-checking bench for sq_carry_resolve: directed scenarios plus random products,
// compared against an arithmetic model (product value, pass count).
module tb_sq_carry_resolve;

    localparam int N  = 130;
    localparam int DW = 16;
    localparam int CW = 8;
    localparam int TW = N * DW + 1;

    typedef logic [N-1:0][DW:0] din_t;

    logic                   clk_sq    = 1'b0;
    logic                   reset_sq  = 1'b0;
    logic                   start     = 1'b0;
    logic                   out_ready = 1'b0;
    din_t                   in_digits = '0;
    logic                   busy;
    logic                   out_valid;
    logic                   carry_out;
    logic [N-1:0][DW-1:0]   out_digits;
`ifdef SQ_RESOLVE_PASSCNT_EN
    logic [CW-1:0]          pass_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [TW-1:0] exp_q[$];
    int            exp_pass_q[$];

    sq_carry_resolve #(.NUM_DIGITS(N), .DIGIT_W(DW), .CNT_W(CW)) dut (
        .clk_sq     (clk_sq),
        .reset_sq   (reset_sq),
        .start      (start),
        .in_digits  (in_digits),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_digits (out_digits),
        .carry_out  (carry_out)
`ifdef SQ_RESOLVE_PASSCNT_EN
        ,
        .pass_cnt   (pass_cnt)
`endif
    );

    // Clock
    always #5 clk_sq = ~clk_sq;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Model: the resolved product is the plain sum of the weighted digits; the bit
    // above the top digit is the carry out.
    function automatic logic [TW-1:0] model_value(input din_t d);
        logic [TW-1:0] s;
        logic [TW-1:0] t;
        s = '0;
        for (int i = 0; i < N; i++) begin
            t = '0;
            t[DW:0] = d[i];
            s = s + (t << (DW * i));
        end
        return s;
    endfunction

    function automatic int model_passes(input din_t d);
        int w[N];
        int nw[N];
        int passes;
        bit pending;
        for (int i = 0; i < N; i++) w[i] = int'(d[i]);
        passes = 0;
        for (int p = 0; p < 4 * N; p++) begin
            pending = 1'b0;
            for (int i = 0; i < N; i++) if (w[i] > 'hFFFF) pending = 1'b1;
            if (!pending) break;
            nw[0] = w[0] % 65536;
            for (int i = 1; i < N; i++) nw[i] = (w[i] % 65536) + (w[i-1] / 65536);
            w = nw;
            passes++;
        end
        return passes;
    endfunction

    function automatic din_t rand_digits();
        din_t d;
        for (int i = 0; i < N; i++) begin
            d[i][DW-1:0] = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
            d[i][DW]     = ($urandom_range(0, 3) == 0);
        end
        return d;
    endfunction

    task automatic check_digits(input string tag, input logic [TW-1:0] ev);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_digit%0d", tag, i), 32'(out_digits[i]), 32'(ev[DW*i +: DW]));
        end
    endtask

    // Driver: issue one request, wait for out_valid, check, hold, then hand off.
    task automatic run_op(input string tag, input din_t d, input int hold, input bit scramble);
        logic [TW-1:0] ev;
        int ep;
        int cyc;
        int idx;
        exp_q.push_back(model_value(d));
        exp_pass_q.push_back(model_passes(d));
        @(negedge clk_sq);
        in_digits = d;
        start     = 1'b1;
        @(posedge clk_sq);
        #1;
        start = 1'b0;
        if (scramble) in_digits = rand_digits();
        cyc = 1;
        forever begin
            @(negedge clk_sq);
            if (out_valid) break;
            if (cyc >= N + 20) break;
            @(posedge clk_sq);
            #1;
            if (scramble) in_digits = rand_digits();
            cyc++;
        end
        ev = exp_q.pop_front();
        ep = exp_pass_q.pop_front();
        if (!out_valid) begin
            check({tag, "_valid_timeout"}, 32'(out_valid), 32'd1);
            return;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(ep + 2));
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_carry"}, 32'(carry_out), 32'(ev[TW-1]));
`ifdef SQ_RESOLVE_PASSCNT_EN
        check({tag, "_pass_cnt"}, 32'(pass_cnt), 32'(ep));
`endif
        check_digits(tag, ev);
        for (int j = 0; j < hold; j++) begin
            start = 1'($urandom_range(0, 1));
            @(posedge clk_sq);
            #1;
            start = 1'b0;
            @(negedge clk_sq);
            idx = $urandom_range(0, N - 1);
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_busy"}, 32'(busy), 32'd1);
            check({tag, "_hold_carry"}, 32'(carry_out), 32'(ev[TW-1]));
            check({tag, "_hold_digit"}, 32'(out_digits[idx]), 32'(ev[DW*idx +: DW]));
        end
        if (hold > 0) check_digits({tag, "_held"}, ev);
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk_sq);
        #1;
        out_ready = 1'b0;
        start     = 1'b0;
        @(negedge clk_sq);
        check({tag, "_release_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_release_busy"}, 32'(busy), 32'd0);
    endtask

    din_t t1, t2, t3;

    initial begin
        for (int i = 0; i < N; i++) begin
            t1[i] = 17'h00001;
            t2[i] = (i == 0) ? 17'h1FFFF : 17'h0FFFF;
            t3[i] = (i == 5) ? 17'h10003 : 17'h00000;
        end

        // Reset state
        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_carry", 32'(carry_out), 32'd0);
        check("reset_digits_or", 32'(|out_digits), 32'd0);
        @(negedge clk_sq);
        reset_sq = 1'b1;

        run_op("t1", t1, 0, 1'b0);
        run_op("t2", t2, 0, 1'b0);
        run_op("t3", t3, 0, 1'b0);
        run_op("t4", t1, 10, 1'b0);
        run_op("t4_next", t3, 1, 1'b0);

        // Abort in the middle of a long carry chain
        @(negedge clk_sq);
        in_digits = t2;
        start     = 1'b1;
        @(posedge clk_sq);
        #1;
        start = 1'b0;
        repeat (40) @(posedge clk_sq);
        #2;
        check("t5_prop_busy", 32'(busy), 32'd1);
        check("t5_prop_valid", 32'(out_valid), 32'd0);
        reset_sq = 1'b0;
        #1;
        check("t5_abort_busy", 32'(busy), 32'd0);
        check("t5_abort_valid", 32'(out_valid), 32'd0);
        check("t5_abort_carry", 32'(carry_out), 32'd0);
        check("t5_abort_digits_or", 32'(|out_digits), 32'd0);
`ifdef SQ_RESOLVE_PASSCNT_EN
        check("t5_abort_pass_cnt", 32'(pass_cnt), 32'd0);
`endif
        @(negedge clk_sq);
        reset_sq = 1'b1;
        run_op("t5_after", t1, 0, 1'b0);

        run_op("t6", rand_digits(), 2, 1'b1);

        for (int k = 0; k < 8; k++) begin
            run_op($sformatf("rand%0d", k), rand_digits(), $urandom_range(0, 3), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
